// File: rtl/prach_ch_acc.sv
// prach_ch_acc: per-channel, per-lane accumulator that emits the average of ACC_LEN frames.
// Define PRACH_CH_ACC_ROUND_EN to round the average half up instead of truncating it.
module prach_ch_acc #(
  parameter int NUM_CH  = 48,
  parameter int ACC_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] din_dp1,
  input  logic signed [15:0] din_dp2,
  input  logic               din_dv,
  input  logic        [7:0]  din_chn,
  input  logic               sync_in,
  output logic signed [15:0] dout_dp1,
  output logic signed [15:0] dout_dp2,
  output logic               dout_dv,
  output logic        [7:0]  dout_chn,
  output logic               sync_out
);

  localparam int L  = $clog2(ACC_LEN);
  localparam int AW = 16 + L;
  localparam int FW = (L > 0) ? L : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic signed [AW-1:0] acc1 [NUM_CH];
  logic signed [AW-1:0] acc2 [NUM_CH];

  logic [FW-1:0]        f_cnt;
  logic [FW-1:0]        f_eff;
  logic [CW-1:0]        idx;
  logic                 in_range;
  logic                 valid;
  logic                 last_ch;
  logic                 frame_first;
  logic                 frame_last;
  logic signed [AW-1:0] base1;
  logic signed [AW-1:0] base2;
  logic signed [AW-1:0] sum1;
  logic signed [AW-1:0] sum2;
  logic signed [15:0]   avg1;
  logic signed [15:0]   avg2;

  assign idx         = din_chn[CW-1:0];
  assign in_range    = ({1'b0, din_chn} < 9'(NUM_CH));
  assign valid       = din_dv & in_range;
  assign last_ch     = (din_chn == 8'(NUM_CH - 1));
  assign f_eff       = sync_in ? '0 : f_cnt;
  assign frame_first = (f_eff == '0);
  assign frame_last  = (f_eff == FW'(ACC_LEN - 1));

  // The first frame of a period sees zero history, so overwrite and accumulate share one adder.
  assign base1 = frame_first ? '0 : acc1[idx];
  assign base2 = frame_first ? '0 : acc2[idx];
  assign sum1  = base1 + AW'(din_dp1);
  assign sum2  = base2 + AW'(din_dp2);

`ifdef PRACH_CH_ACC_ROUND_EN
  localparam int RND = ACC_LEN / 2;

  logic signed [AW:0] rnd1;
  logic signed [AW:0] rnd2;

  // One extra bit keeps the half-LSB bias from wrapping a full-scale positive sum.
  assign rnd1 = (AW+1)'(sum1) + (AW+1)'(RND);
  assign rnd2 = (AW+1)'(sum2) + (AW+1)'(RND);
  assign avg1 = 16'(rnd1 >>> L);
  assign avg2 = 16'(rnd2 >>> L);
`else
  assign avg1 = 16'(sum1 >>> L);
  assign avg2 = 16'(sum2 >>> L);
`endif

  // Accumulators are left unreset; f_cnt restarts at 0 so the next frame overwrites them.
  always_ff @(posedge clk) begin
    if (valid) begin
      acc1[idx] <= sum1;
      acc2[idx] <= sum2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_cnt <= '0;
    end else if (valid && last_ch) begin
      f_cnt <= frame_last ? '0 : f_eff + 1'b1;
    end else if (sync_in) begin
      f_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_dp1 <= '0;
      dout_dp2 <= '0;
      dout_dv  <= 1'b0;
      dout_chn <= '0;
      sync_out <= 1'b0;
    end else begin
      dout_dv  <= valid & frame_last;
      sync_out <= sync_in;
      if (valid && frame_last) begin
        dout_dp1 <= avg1;
        dout_dp2 <= avg2;
        dout_chn <= din_chn;
      end
    end
  end

endmodule

// File: tb/tb_prach_ch_acc.sv
// tb_prach_ch_acc: randomized and directed checks of prach_ch_acc against a frame-average model.
// A second instance with ACC_LEN=1 shares the inputs and must echo every valid sample.
`timescale 1ns/1ps
module tb_prach_ch_acc;

  localparam int NUM_CH = 48;
  localparam int ACC    = 4;
`ifdef PRACH_CH_ACC_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic signed [15:0] din_dp1;
  logic signed [15:0] din_dp2;
  logic               din_dv;
  logic        [7:0]  din_chn;
  logic               sync_in;
  logic signed [15:0] dout_dp1;
  logic signed [15:0] dout_dp2;
  logic               dout_dv;
  logic        [7:0]  dout_chn;
  logic               sync_out;
  logic signed [15:0] pass_dp1;
  logic signed [15:0] pass_dp2;
  logic               pass_dv;
  logic        [7:0]  pass_chn;
  logic               pass_sync;

  int errors = 0;
  int checks = 0;

  int m_fcnt;
  int m_sum1 [NUM_CH];
  int m_sum2 [NUM_CH];
  int exp_dv, exp_dp1, exp_dp2, exp_chn, exp_sync;
  int exp_pdv, exp_pdp1, exp_pdp2, exp_pchn, exp_psync;

  int cap_dp1 [256];
  int cap_dp2 [256];
  int cap_cnt [256];
  int out_total = 0;

  logic signed [15:0] fd1 [NUM_CH];
  logic signed [15:0] fd2 [NUM_CH];

  prach_ch_acc #(.NUM_CH(NUM_CH), .ACC_LEN(ACC)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .din_dp1(din_dp1), .din_dp2(din_dp2), .din_dv(din_dv), .din_chn(din_chn), .sync_in(sync_in),
    .dout_dp1(dout_dp1), .dout_dp2(dout_dp2), .dout_dv(dout_dv), .dout_chn(dout_chn), .sync_out(sync_out)
  );

  prach_ch_acc #(.NUM_CH(NUM_CH), .ACC_LEN(1)) u_pass (
    .clk(clk), .rst_n(rst_n),
    .din_dp1(din_dp1), .din_dp2(din_dp2), .din_dv(din_dv), .din_chn(din_chn), .sync_in(sync_in),
    .dout_dp1(pass_dp1), .dout_dp2(pass_dp2), .dout_dv(pass_dv), .dout_chn(pass_chn), .sync_out(pass_sync)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Average of ACC frames as a floor division, optionally biased by half an LSB first.
  function automatic int avg_of(input int s);
    int t;
    int q;
    t = ROUND ? s + ACC / 2 : s;
    q = t / ACC;
    if ((t % ACC) != 0 && t < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_fcnt = 0;
    exp_dv = 0; exp_dp1 = 0; exp_dp2 = 0; exp_chn = 0; exp_sync = 0;
    exp_pdv = 0; exp_pdp1 = 0; exp_pdp2 = 0; exp_pchn = 0; exp_psync = 0;
  endtask

  task automatic model_step();
    int c;
    int feff;
    bit valid;
    if (!rst_n) begin
      model_reset();
      return;
    end
    c     = int'(din_chn);
    valid = din_dv && (c < NUM_CH);
    feff  = sync_in ? 0 : m_fcnt;
    exp_dv    = 0;
    exp_pdv   = 0;
    exp_sync  = int'(sync_in);
    exp_psync = int'(sync_in);
    if (valid) begin
      m_sum1[c] = (feff == 0) ? int'(din_dp1) : m_sum1[c] + int'(din_dp1);
      m_sum2[c] = (feff == 0) ? int'(din_dp2) : m_sum2[c] + int'(din_dp2);
      if (feff == ACC - 1) begin
        exp_dv  = 1;
        exp_dp1 = avg_of(m_sum1[c]);
        exp_dp2 = avg_of(m_sum2[c]);
        exp_chn = c;
      end
      exp_pdv  = 1;
      exp_pdp1 = int'(din_dp1);
      exp_pdp2 = int'(din_dp2);
      exp_pchn = c;
      if (c == NUM_CH - 1) m_fcnt = (feff == ACC - 1) ? 0 : feff + 1;
      else if (sync_in) m_fcnt = 0;
    end else if (sync_in) begin
      m_fcnt = 0;
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic [7:0] chn, input logic signed [15:0] a,
                               input logic signed [15:0] b, input logic sync);
    din_dv = dv; din_chn = chn; din_dp1 = a; din_dp2 = b; sync_in = sync;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'd0, 16'sd0, 16'sd0, 1'b0);
  endtask

  task automatic run_frame(input bit sync_first, input bit gaps, input int n_ch);
    for (int c = 0; c < n_ch; c++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0)
          applyStimulus(1'b0, 8'($urandom_range(0, 255)), 16'($urandom), 16'($urandom), 1'b0);
        else
          applyStimulus(1'b1, 8'($urandom_range(NUM_CH, 63)), 16'($urandom), 16'($urandom), 1'b0);
      end
      applyStimulus(1'b1, 8'(c), fd1[c], fd2[c], sync_first && (c == 0));
    end
  endtask

  task automatic fill_rand();
    for (int c = 0; c < NUM_CH; c++) begin
      fd1[c] = 16'($urandom);
      fd2[c] = 16'($urandom);
    end
  endtask

  task automatic fill_const(input int a, input int b);
    for (int c = 0; c < NUM_CH; c++) begin
      fd1[c] = 16'(a);
      fd2[c] = 16'(b);
    end
  endtask

  // Single compare process: both instances against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("dut_dv",    int'(dout_dv),   exp_dv);
      checkOutput("dut_dp1",   int'(dout_dp1),  exp_dp1);
      checkOutput("dut_dp2",   int'(dout_dp2),  exp_dp2);
      checkOutput("dut_chn",   int'(dout_chn),  exp_chn);
      checkOutput("dut_sync",  int'(sync_out),  exp_sync);
      checkOutput("pass_dv",   int'(pass_dv),   exp_pdv);
      checkOutput("pass_dp1",  int'(pass_dp1),  exp_pdp1);
      checkOutput("pass_dp2",  int'(pass_dp2),  exp_pdp2);
      checkOutput("pass_chn",  int'(pass_chn),  exp_pchn);
      checkOutput("pass_sync", int'(pass_sync), exp_psync);
      if (dout_dv) begin
        cap_dp1[dout_chn] = int'(dout_dp1);
        cap_dp2[dout_chn] = int'(dout_dp2);
        cap_cnt[dout_chn] = cap_cnt[dout_chn] + 1;
        out_total++;
      end
    end
  end

  initial begin
    int snap;
    din_dv = 1'b0; din_chn = 8'd0; din_dp1 = 16'sd0; din_dp2 = 16'sd0; sync_in = 1'b0;
    #1;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dv", int'(dout_dv), 0);
    checkOutput("rst_dp1", int'(dout_dp1), 0);
    checkOutput("rst_sync", int'(sync_out), 0);
    rst_n = 1'b1;

    checkOutput("model_pin_pos", avg_of(46), ROUND ? 12 : 11);
    checkOutput("model_pin_neg", avg_of(-46), ROUND ? -11 : -12);

    // Basic averaging on channel 5, lane 1.
    for (int f = 0; f < ACC; f++) begin
      fill_rand();
      fd1[5] = 16'(10 + f);
      run_frame(f == 0, 1'b0, NUM_CH);
    end
    idle();
    checkOutput("avg_ch5_dp1", cap_dp1[5], ROUND ? 12 : 11);
    checkOutput("avg_ch5_cnt", cap_cnt[5], 1);

    // Out-of-range samples and dv gaps must not disturb the averages.
    snap = out_total;
    for (int f = 0; f < 8; f++) begin
      fill_rand();
      run_frame(1'b0, 1'b1, NUM_CH);
    end
    idle();
    checkOutput("gap_out_count", out_total - snap, 2 * NUM_CH);

    // Full-scale inputs must not wrap.
    fill_const(-32768, -32768);
    repeat (ACC) run_frame(1'b0, 1'b0, NUM_CH);
    idle();
    checkOutput("neg_ext_dp1", cap_dp1[10], -32768);
    checkOutput("neg_ext_dp2", cap_dp2[47], -32768);
    fill_const(32767, 32767);
    repeat (ACC) run_frame(1'b0, 1'b0, NUM_CH);
    idle();
    checkOutput("pos_ext_dp1", cap_dp1[10], 32767);
    checkOutput("pos_ext_dp2", cap_dp2[47], 32767);

    applyStimulus(1'b1, 8'd7, 16'sd1234, -16'sd5, 1'b0);
    checkOutput("echo_dp1", int'(pass_dp1), 1234);
    checkOutput("echo_dp2", int'(pass_dp2), -5);
    checkOutput("echo_dv", int'(pass_dv), 1);
    checkOutput("echo_main_dv", int'(dout_dv), 0);
    idle();

    // Resync in the middle of frame 2.
    fill_const(1000, 1000);
    run_frame(1'b0, 1'b0, NUM_CH);
    run_frame(1'b0, 1'b0, NUM_CH);
    fill_const(30000, 30000);
    run_frame(1'b0, 1'b0, 21);
    snap = cap_cnt[0];
    for (int f = 0; f < ACC - 1; f++) begin
      fill_const(100 * (f + 1), -100 * (f + 1));
      run_frame(f == 0, 1'b0, NUM_CH);
    end
    checkOutput("resync_no_early", cap_cnt[0], snap);
    fill_const(100 * ACC, -100 * ACC);
    run_frame(1'b0, 1'b0, NUM_CH);
    idle();
    checkOutput("resync_cnt", cap_cnt[0], snap + 1);
    checkOutput("resync_dp1_ch0", cap_dp1[0], 250);
    checkOutput("resync_dp2_ch20", cap_dp2[20], -250);
    checkOutput("resync_dp1_ch47", cap_dp1[47], 250);

    // Reset during frame 2.
    fill_const(555, 555);
    run_frame(1'b0, 1'b0, NUM_CH);
    run_frame(1'b0, 1'b0, NUM_CH);
    run_frame(1'b0, 1'b0, 30);
    #2;
    rst_n = 1'b0;
    din_dv = 1'b0;
    model_reset();
    #1;
    checkOutput("midrst_dv", int'(dout_dv), 0);
    checkOutput("midrst_dp1", int'(dout_dp1), 0);
    checkOutput("midrst_dp2", int'(dout_dp2), 0);
    checkOutput("midrst_chn", int'(dout_chn), 0);
    checkOutput("midrst_pass_dp1", int'(pass_dp1), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    snap = cap_cnt[40];
    fill_const(-8, 77);
    repeat (ACC - 1) run_frame(1'b0, 1'b0, NUM_CH);
    checkOutput("postrst_no_early", cap_cnt[40], snap);
    run_frame(1'b0, 1'b0, NUM_CH);
    idle();
    checkOutput("postrst_cnt", cap_cnt[40], snap + 1);
    checkOutput("postrst_dp1", cap_dp1[40], -8);
    checkOutput("postrst_dp2", cap_dp2[40], 77);
    checkOutput("postrst_dp1_ch0", cap_dp1[0], -8);

    for (int f = 0; f < 4; f++) begin
      fill_rand();
      run_frame(f == 0, 1'b1, NUM_CH);
    end
    repeat (3) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prach_ch_acc.md
PRACH_CH_ACC -- requirements
Module: prach_ch_acc

Interface
REQ-001 SHALL have parameter NUM_CH, default 48: number of valid channels, indices 0..NUM_CH-1, range 1..256.
REQ-002 SHALL have parameter ACC_LEN, default 4: frames accumulated per output, power of two, 1..64; L = log2(ACC_LEN).
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports din_dp1 and din_dp2, input, 16 bits each: signed two's-complement lane samples from the channel reshape stage.
REQ-006 SHALL have port din_dv, input, 1 bit: input sample valid.
REQ-007 SHALL have port din_chn, input, 8 bits: channel index of the current input pair.
REQ-008 SHALL have port sync_in, input, 1 bit: frame-start marker, coincident with a sample.
REQ-009 SHALL have ports dout_dp1 and dout_dp2, output, 16 bits each: signed averaged lane results.
REQ-010 SHALL have port dout_dv, output, 1 bit: result valid.
REQ-011 SHALL have ports dout_chn, output, 8 bits, and sync_out, output, 1 bit: result channel index and the delayed frame marker.

Function
REQ-012 SHALL hold one accumulator per channel per lane, each 16+L bits signed, stored in registers (not RAM), so that consecutive accesses to the same channel cause no hazard.
REQ-013 SHALL keep a frame counter f_cnt with range 0..ACC_LEN-1; the effective frame f_eff is 0 when sync_in=1 and f_cnt otherwise.
REQ-014 SHALL, on a valid sample (din_dv=1, din_chn<NUM_CH) with f_eff=0, overwrite acc[chn] with the sign-extended input.
REQ-015 SHALL, on a valid sample with f_eff>0, set acc[chn] = acc[chn] + sign-extended input; the sum never overflows 16+L bits.
REQ-016 SHALL, on a valid sample with f_eff=ACC_LEN-1, compute sum = acc[chn] + input (or the input alone when ACC_LEN=1) and emit it one cycle later.
- dout_dp = sum >> L (arithmetic shift), per REQ-026/027.
- dout_dv = 1 and dout_chn = din_chn.
REQ-017 SHALL drive dout_dv=0 in all other cycles; when dout_dv=0, dout_dp1, dout_dp2 and dout_chn hold their last values.
REQ-018 SHALL advance f_cnt on din_dv=1 with din_chn=NUM_CH-1: to 0 if f_eff=ACC_LEN-1, else to f_eff+1.
REQ-019 SHALL set f_cnt to 0 when sync_in=1 without a last-channel valid sample.
- With a last-channel valid sample, REQ-018 applies using f_eff=0.
REQ-020 SHALL treat samples with din_chn>=NUM_CH as non-valid: no accumulator update, no output, no f_cnt advance.
REQ-021 SHALL make no state change when din_dv=0, except the sync_in rule of REQ-019.
REQ-022 SHALL register sync_out = sync_in with 1-cycle latency, independent of din_dv.
REQ-023 SHALL have a fixed latency of 1 cycle from input to output for all outputs.

Reset
REQ-024 SHALL, while rst_n=0, force dout_dp1=0, dout_dp2=0, dout_dv=0, dout_chn=0, sync_out=0 and f_cnt=0.
REQ-025 SHALL leave accumulators unreset; because f_cnt=0 after reset, the first post-reset frame overwrites them, and reset mid-accumulation discards the partial sums.

Configuration
REQ-026 SHALL, when macro PRACH_CH_ACC_ROUND_EN is defined and L>0, add 2^(L-1) to sum before the shift (round half up); intermediate width is 17+L, no saturation needed.
REQ-027 SHALL, when PRACH_CH_ACC_ROUND_EN is undefined or L=0, truncate (plain arithmetic shift, floor).

Verification
REQ-028 Bench SHALL check basic averaging: ACC_LEN=4, NUM_CH=48, sync at frame 0, channel 5 lane1 inputs 10, 11, 12, 13 -> single dout_dv on frame 3, chn=5, dp1=11 (truncate) or 12 (ROUND_EN).
REQ-029 Bench SHALL check the negative extreme: all inputs -32768 for 4 frames -> dp=-32768; all inputs 32767 -> dp=32767 in both macro builds, no wrap.
REQ-030 Bench SHALL check resync: sync_in asserted mid-frame 2 on channel 0 -> f_cnt restarts at 0, and the next output appears 4 full frames later with values from post-sync samples only.
REQ-031 Bench SHALL check out-of-range and gap handling: din_chn=48..63 with din_dv=1, and din_dv=0 gaps inserted -> no dout_dv, f_cnt unaffected, results identical to the gap-free run.
REQ-032 Bench SHALL check reset mid-operation: rst_n low during frame 2 -> all outputs 0 immediately, and the first output after release comes at frame 3 of the new count using only post-reset data.
REQ-033 Bench SHALL check pass-through: ACC_LEN=1 -> every valid input is echoed with 1-cycle latency, dout_dv=1, values unchanged.
